// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-RAM arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DBG = 2'd2
    } arb_state_t;

    localparam logic [2:0] UBHW_W   = 3'b010;
    localparam int         CNT_W    = 3;
    localparam int         STARVE_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of CPU grants taken while debug waits
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-RAM port between the MEM stage and the debug port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_ubhw,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic [2:0]  ram_ubhw,
    input  logic [31:0] ram_rdata
);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      lat_addr, lat_wdata;
    logic [2:0]       lat_ubhw;
    logic             dbg_win, cpu_win, starve_sat, last_cycle;

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (cpu_win & dbg_req),
        .clr (dbg_win | ~dbg_req),
        .sat (starve_sat)
    );

    assign last_cycle = (cnt == '0);

    // Grants are only decided in IDLE and are suppressed while reset is held.
    always_comb begin
        dbg_win = 1'b0;
        cpu_win = 1'b0;
        if (!rst && state == IDLE) begin
            dbg_win = dbg_req & (~cpu_req | starve_sat);
            cpu_win = ~dbg_win & cpu_req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_ubhw  = '0;
        case (state)
            IDLE: begin
                if (dbg_win) begin
                    ram_addr  = dbg_addr;
                    ram_wdata = dbg_wdata;
                    ram_we    = dbg_we;
                    ram_ubhw  = UBHW_W;
                    state_nxt = BUSY_DBG;
                    cnt_nxt   = CNT_W'(RAM_LAT - 1);
                end else if (cpu_win) begin
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                    ram_we    = cpu_we;
                    ram_ubhw  = cpu_ubhw;
                    state_nxt = BUSY_CPU;
                    cnt_nxt   = CNT_W'(RAM_LAT - 1);
                end
            end
            BUSY_CPU, BUSY_DBG: begin
                ram_addr  = lat_addr;
                ram_wdata = lat_wdata;
                ram_ubhw  = lat_ubhw;
                if (last_cycle) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_ubhw  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (dbg_win || cpu_win) begin
                lat_addr  <= ram_addr;
                lat_wdata <= ram_wdata;
                lat_ubhw  <= ram_ubhw;
            end
        end
    end

    assign cpu_stall = cpu_req & ~((state == BUSY_CPU) & last_cycle);
    assign cpu_rdata = ram_rdata;
    assign dbg_ack   = (state == BUSY_DBG) & last_cycle;
    assign dbg_rdata = ram_rdata;

endmodule
